vram_dumper: RTL and testbench
==============================

# vram_dumper

UART-side VRAM read-back engine: the reverse path of the UART VRAM loader. It accepts a 5-byte dump command from the host over the existing `uart` receive interface. It then reads the requested VRAM range through a dedicated read port and streams each byte back through the `uart` transmit interface. It sits beside the loader in `top`, sharing the `uart` instance and owning one VRAM port, so the host can verify uploaded tile, name-table and CRAM-adjacent data.

## Interface
- `OPCODE`, 8'h44 ('D'): command byte that starts a dump.
- `ADDR_W`, 14: VRAM address width.
- `clk`  in  1  system clock, same clock as the VRAM port driven.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from `uart`; valid in the cycle `rx_done` is high.
- `rx_done`  in  1  one-cycle pulse per received byte.
- `tx_data`  out  8  byte to transmit; reset 8'h00.
- `tx_wr`  out  1  one-cycle transmit strobe; reset 0.
- `tx_done`  in  1  one-cycle pulse when `uart` finishes a byte.
- `vram_addr`  out  ADDR_W  VRAM read address, registered; reset 0.
- `vram_do`  in  8  VRAM read data, synchronous read, 1-cycle latency.
- `busy`  out  1  high from the accepted opcode until the last byte's `tx_done`; reset 0.

## Operation
- Command format: `OPCODE`, `addr_hi` (bits 13:8; upper 2 bits ignored), `addr_lo`, `len_hi` (bits 13:8; upper 2 bits ignored), `len_lo`.
- `len` == 0 means 2^ADDR_W bytes (full 16 KiB).
- States:
  - S_IDLE: on `rx_done` with `rx_data`==OPCODE, go to S_ADDR_HI and set `busy`. Any other byte is ignored and the state stays S_IDLE.
  - S_ADDR_HI → S_ADDR_LO → S_LEN_HI → S_LEN_LO: each state advances on `rx_done` and latches its byte.
  - S_LEN_LO → S_READ.
  - S_READ: drive `vram_addr` = current address, then go to S_READ_WAIT.
  - S_READ_WAIT: one cycle for RAM latency, then go to S_SEND.
  - S_SEND: latch `vram_do` into `tx_data`, pulse `tx_wr`, then go to S_TX_WAIT.
  - S_TX_WAIT: on `tx_done`, decrement the remaining count and increment the address.
    - If remaining was 1, go to S_IDLE (or S_CSUM when the checksum is enabled).
    - Otherwise go to S_READ.
- Address arithmetic is modulo 2^ADDR_W: 0x3FFF+1 = 0x0000, with no error.
- Remaining count is ADDR_W+1 bits wide so the 0 → 16384 case is representable.
- `rx_done` pulses while the block is streaming (S_READ..S_TX_WAIT) are ignored. No abort exists.
- `tx_done` outside S_TX_WAIT is ignored.
- Reset mid-command or mid-stream returns the block to S_IDLE with all outputs at reset values. A byte that has already started in `uart` completes; the block does not care.

## Timing
- Latency from the `rx_done` of `len_lo` to the first `tx_wr` is 3 cycles (S_READ, S_READ_WAIT, S_SEND).
- `tx_wr` is high for exactly one cycle per byte.
- `tx_data` holds its value from `tx_wr` until the next `tx_wr`.
- Gap between a `tx_done` and the next `tx_wr` is 3 cycles.
- `vram_addr` is stable for at least 2 cycles before `vram_do` is sampled.
- `busy` falls in the cycle after the final `tx_done`, and after the checksum byte's `tx_done` when the checksum is enabled.

## Configuration
- `VRAM_DUMP_CHECKSUM_EN` defined:
  - An 8-bit XOR accumulator clears on opcode acceptance and XORs in every streamed byte at S_SEND.
  - After the last data byte's `tx_done`, S_CSUM sends the accumulator with one `tx_wr`, then S_CSUM_WAIT waits for `tx_done` before going to S_IDLE.
- `VRAM_DUMP_CHECKSUM_EN` undefined: no accumulator and no trailing byte. S_CSUM and S_CSUM_WAIT do not exist.

## Structure
- Shared package / `constants.vh` holds:
  - state encodings (S_IDLE..S_CSUM_WAIT);
  - `VRAM_DUMP_OPCODE`;
  - `VRAM_ADDR_W` = 14.
- No sub-modules; a single FSM with datapath registers (address, remaining count, optional checksum).

## Test plan
- VRAM[0x3800..0x3803] = 11,22,33,44; send 44,38,00,00,04 → `tx_data` 11,22,33,44 with one `tx_wr` each; `busy` low after the 4th `tx_done`.
- Wrap: VRAM[0x3FFE]=AA, [0x3FFF]=BB, [0x0000]=CC, [0x0001]=DD; send 44,3F,FE,00,04 → AA,BB,CC,DD.
- Send 00,00 (len=0) → exactly 16384 `tx_wr` pulses; addresses 0x0000..0x3FFF in order.
- Bad opcode: send 55 then 44,00,10,00,01 → 55 ignored; one byte VRAM[0x0010] sent.
- Reset: assert `rst_n`=0 after the 2nd `tx_wr` of an 8-byte dump → `tx_wr`=0, `busy`=0, `vram_addr`=0. A new command afterwards dumps correctly.
- With `VRAM_DUMP_CHECKSUM_EN`: dump 11,22,33,44 → 5th byte 0x44 (11^22^33^44).

Source files
------------

// File: rtl/vram_dumper_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vram_dumper_pkg
//  Description : Shared constants and state encoding for the UART VRAM
//                read-back engine (vram_dumper).
//                Optional feature macro: VRAM_DUMP_CHECKSUM_EN adds the
//                trailing XOR checksum states S_CSUM / S_CSUM_WAIT.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_dumper_pkg;

    // VRAM address width; 2^14 = 16 KiB of video memory.
    localparam int VRAM_ADDR_W = 14;

    // Host command byte that opens a dump request ('D').
    localparam logic [7:0] VRAM_DUMP_OPCODE = 8'h44;

    // Dump FSM state encoding.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR_HI   = 4'd1,
        S_ADDR_LO   = 4'd2,
        S_LEN_HI    = 4'd3,
        S_LEN_LO    = 4'd4,
        S_READ      = 4'd5,
        S_READ_WAIT = 4'd6,
        S_SEND      = 4'd7,
`ifdef VRAM_DUMP_CHECKSUM_EN
        S_TX_WAIT   = 4'd8,
        S_CSUM      = 4'd9,
        S_CSUM_WAIT = 4'd10
`else
        S_TX_WAIT   = 4'd8
`endif
    } state_t;

endpackage : vram_dumper_pkg
`default_nettype wire

// File: rtl/vram_dumper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vram_dumper
//  Description : UART-side VRAM read-back engine. Receives a 5-byte dump
//                command (OPCODE, addr_hi, addr_lo, len_hi, len_lo) over the
//                UART receive interface, reads the requested VRAM range
//                through a dedicated synchronous read port and streams each
//                byte back through the UART transmit interface.
//                Optional feature macro: VRAM_DUMP_CHECKSUM_EN appends an
//                8-bit XOR checksum of the streamed bytes after the data.
//
//  Ports
//    clk        in   system clock (same clock as the VRAM port)
//    rst_n      in   asynchronous active-low reset
//    rx_data    in   received byte, valid while rx_done is high
//    rx_done    in   one-cycle pulse per received byte
//    tx_data    out  byte to transmit, held until the next tx_wr
//    tx_wr      out  one-cycle transmit strobe
//    tx_done    in   one-cycle pulse when the UART finishes a byte
//    vram_addr  out  registered VRAM read address
//    vram_do    in   VRAM read data, 1-cycle latency
//    busy       out  high from opcode acceptance until the final tx_done
//
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_dumper
    import vram_dumper_pkg::*;
#(
    parameter logic [7:0] OPCODE = VRAM_DUMP_OPCODE,
    parameter int         ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [7:0]        vram_do,
    output logic              busy
);

    // A length field of zero requests the whole address space, so the
    // remaining counter carries one extra bit to hold 2^ADDR_W.
    localparam logic [ADDR_W:0] c_len_full = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_len_one  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
`ifdef VRAM_DUMP_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    // Full 14-bit length once the low byte arrives; the high part was
    // parked in the counter by S_LEN_HI.
    logic [ADDR_W-1:0] w_len;
    assign w_len = {r_remaining[ADDR_W-1:8], rx_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            tx_data     <= 8'h00;
            tx_wr       <= 1'b0;
            vram_addr   <= '0;
            busy        <= 1'b0;
`ifdef VRAM_DUMP_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            // Strobe is a single-cycle pulse; only S_SEND / S_CSUM raise it.
            tx_wr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rx_done && (rx_data == OPCODE)) begin
                        r_state     <= S_ADDR_HI;
                        busy        <= 1'b1;
                        r_remaining <= '0;
`ifdef VRAM_DUMP_CHECKSUM_EN
                        r_csum      <= 8'h00;
`endif
                    end
                end

                S_ADDR_HI: begin
                    if (rx_done) begin
                        // Upper bits beyond the address width are dropped.
                        r_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
                        r_state            <= S_ADDR_LO;
                    end
                end

                S_ADDR_LO: begin
                    if (rx_done) begin
                        r_addr[7:0] <= rx_data;
                        r_state     <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (rx_done) begin
                        r_remaining[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
                        r_state                 <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (rx_done) begin
                        r_remaining <= (w_len == '0) ? c_len_full : {1'b0, w_len};
                        r_state     <= S_READ;
                    end
                end

                S_READ: begin
                    vram_addr <= r_addr;
                    r_state   <= S_READ_WAIT;
                end

                // The RAM samples vram_addr on this edge; data is ready
                // for S_SEND.
                S_READ_WAIT: begin
                    r_state <= S_SEND;
                end

                S_SEND: begin
                    tx_data <= vram_do;
                    tx_wr   <= 1'b1;
`ifdef VRAM_DUMP_CHECKSUM_EN
                    r_csum  <= r_csum ^ vram_do;
`endif
                    r_state <= S_TX_WAIT;
                end

                S_TX_WAIT: begin
                    if (tx_done) begin
                        r_remaining <= r_remaining - c_len_one;
                        r_addr      <= r_addr + 1'b1;   // wraps modulo 2^ADDR_W
                        if (r_remaining == c_len_one) begin
`ifdef VRAM_DUMP_CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
`endif
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end

`ifdef VRAM_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    tx_data <= r_csum;
                    tx_wr   <= 1'b1;
                    r_state <= S_CSUM_WAIT;
                end

                S_CSUM_WAIT: begin
                    if (tx_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : vram_dumper
`default_nettype wire

// File: tb/tb_vram_dumper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vram_dumper
//  Description : Self-checking bench for vram_dumper. Holds a VRAM model and
//                a UART transmitter model; stimulus pushes the expected byte
//                stream into a scoreboard queue and a monitor pops and
//                compares on every tx_wr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_dumper;
    import vram_dumper_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done;
    logic [13:0] vram_addr;
    logic [7:0]  vram_do;
    logic        busy;

    vram_dumper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done),
        .vram_addr (vram_addr),
        .vram_do   (vram_do),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // VRAM model: synchronous read, one cycle of latency.
    logic [7:0] mem [0:16383];
    always @(posedge clk) vram_do <= mem[vram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        logic [13:0] addr;
        bit          is_csum;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- UART transmitter model + scoreboard monitor ----------
    bit   uart_busy = 1'b0;
    int   uart_cnt  = 0;
    bit   fast_uart = 1'b0;
    int   ref_cyc   = 0;
    bit   ref_valid = 1'b0;
    int   last_done_cyc = 0;
    int   tx_count  = 0;
    int   mon_gap;
    exp_t mon_e;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (rst_n && tx_wr) begin
            tx_count++;
            check("tx_wr_while_uart_busy", {31'd0, uart_busy}, 32'd0);
            if (ref_valid) begin
                // Strobe appears 3 cycles after the edge that samples the
                // last command byte or the previous tx_done.
                mon_gap = 4;
`ifdef VRAM_DUMP_CHECKSUM_EN
                if (exp_q.size() > 0 && exp_q[0].is_csum) mon_gap = 2;
`endif
                check("tx_wr_latency", cyc - ref_cyc, mon_gap);
                ref_valid = 1'b0;
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx_wr: got data %0h expected no byte", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.is_csum ? "tx_checksum" : "tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
                if (!mon_e.is_csum)
                    check("vram_addr_order", {18'd0, vram_addr}, {18'd0, mon_e.addr});
            end
            uart_busy = 1'b1;
            uart_cnt  = fast_uart ? 1 : int'($urandom_range(1, 6));
        end else if (uart_busy) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_done       = 1'b1;
                uart_busy     = 1'b0;
                last_done_cyc = cyc;
                ref_cyc       = cyc;
                ref_valid     = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic send_byte(input logic [7:0] b, input bit last);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        if (last) begin
            ref_cyc   = cyc;
            ref_valid = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Reference model: expected stream for a dump, wrapping modulo 16 KiB.
    task automatic push_expected(input logic [13:0] addr, input logic [13:0] len);
        int          n;
        logic [7:0]  x;
        logic [13:0] a;
        n = (len == 14'd0) ? 16384 : int'(len);
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            a = 14'((int'(addr) + i) % 16384);
            exp_q.push_back('{data: mem[a], addr: a, is_csum: 1'b0});
            x = x ^ mem[a];
        end
`ifdef VRAM_DUMP_CHECKSUM_EN
        exp_q.push_back('{data: x, addr: 14'd0, is_csum: 1'b1});
`endif
    endtask

    task automatic send_cmd(input logic [13:0] addr, input logic [13:0] len);
        logic [1:0] junk_a, junk_l;
        junk_a = 2'($urandom);
        junk_l = 2'($urandom);
        send_byte(VRAM_DUMP_OPCODE, 1'b0);
        send_byte({junk_a, addr[13:8]}, 1'b0);
        send_byte(addr[7:0], 1'b0);
        send_byte({junk_l, len[13:8]}, 1'b0);
        send_byte(len[7:0], 1'b1);
    endtask

    // Waits for busy to drop, sprinkling ignored rx bytes while streaming.
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        check("busy_while_streaming", {31'd0, busy}, 32'd1);
        forever begin
            @(negedge clk);
            rx_done = 1'b0;
            if (!busy) break;
            if (k >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL busy_timeout: busy still %0b expected 0 after %0d cycles", busy, budget);
                break;
            end
            if ($urandom_range(0, 15) == 0) begin
                rx_data = 8'($urandom);
                rx_done = 1'b1;
            end
            k++;
        end
        rx_done = 1'b0;
        check("busy_fall_timing", cyc - last_done_cyc, 1);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic dump(input logic [13:0] addr, input logic [13:0] len);
        push_expected(addr, len);
        send_cmd(addr, len);
        wait_idle((len == 14'd0) ? 100000 : 64 * int'(len) + 200);
    endtask

    task automatic wait_uart_idle();
        int k;
        k = 0;
        while (uart_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("uart_idle", {31'd0, uart_busy}, 32'd0);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        int          start;
        int          k;
        logic [7:0]  b;
        logic [13:0] ra;

        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("reset_tx_wr",     {31'd0, tx_wr},     32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        check("reset_vram_addr", {18'd0, vram_addr}, 32'd0);
        check("reset_tx_data",   {24'd0, tx_data},   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        // Basic 4-byte dump.
        mem[14'h3800] = 8'h11; mem[14'h3801] = 8'h22;
        mem[14'h3802] = 8'h33; mem[14'h3803] = 8'h44;
        dump(14'h3800, 14'd4);

        // Address wrap at the top of VRAM.
        mem[14'h3FFE] = 8'hAA; mem[14'h3FFF] = 8'hBB;
        mem[14'h0000] = 8'hCC; mem[14'h0001] = 8'hDD;
        dump(14'h3FFE, 14'd4);

        // Bad opcode and other stray bytes are ignored in idle.
        send_byte(8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            if (b == VRAM_DUMP_OPCODE) b = 8'h00;
            send_byte(b, 1'b0);
        end
        check("stray_byte_busy", {31'd0, busy}, 32'd0);
        dump(14'h0010, 14'd1);

        // Randomized dumps, some straddling the wrap point.
        for (int t = 0; t < 6; t++) begin
            ra = (t % 2 == 0) ? 14'(16384 - $urandom_range(1, 10)) : 14'($urandom);
            dump(ra, 14'($urandom_range(1, 24)));
        end

        // Reset in the middle of an 8-byte stream.
        push_expected(14'h0100, 14'd8);
        send_cmd(14'h0100, 14'd8);
        start = tx_count;
        k = 0;
        while (tx_count < start + 2 && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("reset_test_two_bytes", tx_count - start, 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_tx_wr",     {31'd0, tx_wr},     32'd0);
        check("midreset_busy",      {31'd0, busy},      32'd0);
        check("midreset_vram_addr", {18'd0, vram_addr}, 32'd0);
        exp_q.delete();
        ref_valid = 1'b0;
        rst_n = 1'b1;
        wait_uart_idle();
        repeat (2) @(negedge clk);
        ref_valid = 1'b0;
        check("after_reset_busy", {31'd0, busy}, 32'd0);
        dump(14'h0200, 14'd8);

        // len == 0 dumps the full 16 KiB.
        fast_uart = 1'b1;
        start = tx_count;
        dump(14'h0000, 14'd0);
`ifdef VRAM_DUMP_CHECKSUM_EN
        check("full_dump_count", tx_count - start, 16385);
`else
        check("full_dump_count", tx_count - start, 16384);
`endif
        fast_uart = 1'b0;

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_vram_dumper
`default_nettype wire
